// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and ARMv8 constants.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] ARM_NOP  = 32'hD503201F;
  localparam logic [31:0] ARM_HLT0 = 32'hD4400000;

  // Force an address onto a 4-byte instruction boundary.
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return addr & ~64'd3;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: hazard/branch inputs, IM port and IF/ID outputs.
interface fetch_controller_if;
  logic        Stall;
  logic        BranchTaken;
  logic [63:0] BranchTarget;
  logic [63:0] Address;
  logic [31:0] Instruction;
  logic [63:0] IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic        Halted;
  logic [31:0] FetchCount;

  modport master (
    input  Stall, BranchTaken, BranchTarget, Instruction,
    output Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid, Halted, FetchCount
  );

  modport slave (
    output Stall, BranchTaken, BranchTarget, Instruction,
    input  Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid, Halted, FetchCount
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect > hold > step priority; step wraps mod 2^64.
module fetch_pc_reg
  import fetch_controller_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic        hold,
  input  logic [63:0] target,
  output logic [63:0] pc
);

  logic [63:0] pc_next;

  // Next-PC selection.
  always_comb begin
    if (redirect)  pc_next = align_word(target);
    else if (hold) pc_next = pc;
    else           pc_next = pc + 64'(PC_STEP);
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: start delay, stall, branch redirect/flush, halt.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned START_DELAY = 2,
  parameter logic [31:0] HALT_WORD   = ARM_HLT0,
  parameter logic [31:0] NOP_WORD    = ARM_NOP
) (
  input  logic CLK,
  input  logic RESET,
  fetch_controller_if.master bus
);

  // A zero start delay skips WAIT entirely, so fetch begins on the first edge after reset.
  localparam fetch_state_t RESET_STATE = (START_DELAY == 0) ? ST_RUN : ST_WAIT;
  localparam logic [31:0]  DELAY_LAST  = (START_DELAY == 0) ? 32'd0 : 32'(START_DELAY - 1);

  fetch_state_t state, state_next;
  logic [31:0]  delay_cnt;
  logic [63:0]  pc;
  logic         is_halt;
  logic         fetch, bubble, pc_hold, halted;
  logic [63:0]  if_id_pc;
  logic [31:0]  if_id_instr;
  logic         if_id_valid;
  logic [31:0]  fetch_count;

  assign is_halt = (bus.Instruction == HALT_WORD);

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk      (CLK),
    .rst      (RESET),
    .redirect (bus.BranchTaken),
    .hold     (pc_hold),
    .target   (bus.BranchTarget),
    .pc       (pc)
  );

  // State register and start-delay counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= RESET_STATE;
      delay_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_WAIT) delay_cnt <= delay_cnt + 32'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT: if (delay_cnt == DELAY_LAST) state_next = ST_RUN;
      ST_RUN:  if (!bus.BranchTaken && !bus.Stall && is_halt) state_next = ST_HALT;
      ST_HALT: if (bus.BranchTaken) state_next = ST_RUN;
      default: state_next = RESET_STATE;
    endcase
  end

  // Per-state control: capture, flush, PC hold and halt flag.
  always_comb begin
    fetch   = 1'b0;
    bubble  = 1'b0;
    pc_hold = 1'b1;
    halted  = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.BranchTaken) begin
          bubble = 1'b1;
        end else if (!bus.Stall) begin
          fetch   = 1'b1;
          pc_hold = is_halt;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // IF/ID pipeline register and delivered-instruction counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (fetch) begin
      if_id_pc    <= pc;
      if_id_instr <= bus.Instruction;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end else if (bubble) begin
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
    end
  end

  assign bus.Address           = pc;
  assign bus.IF_ID_PC          = if_id_pc;
  assign bus.IF_ID_Instruction = if_id_instr;
  assign bus.IF_ID_Valid       = if_id_valid;
  assign bus.Halted            = halted;
  assign bus.FetchCount        = fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed plus randomized bench for fetch_controller against a behavioural model.
module tb_fetch_controller;

  localparam logic [31:0] NOP      = 32'hD503201F;
  localparam logic [31:0] HLT      = 32'hD4400000;
  localparam int          D0_DELAY = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, stall, br;
  logic [63:0] tgt;
  logic [31:0] instr;
  logic [63:0] halt_addr;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [63:0] m_pc, m_if_pc;
  logic [31:0] m_if_instr, m_count;
  logic        m_if_valid, m_halted;
  int          m_idle;

  fetch_controller_if bus0 ();
  fetch_controller_if bus1 ();

  assign bus0.Stall        = stall;
  assign bus0.BranchTaken  = br;
  assign bus0.BranchTarget = tgt;
  assign bus0.Instruction  = instr;

  assign bus1.Stall        = 1'b0;
  assign bus1.BranchTaken  = 1'b0;
  assign bus1.BranchTarget = 64'h0;
  assign bus1.Instruction  = bus1.Address[31:0] + 32'h100;

  fetch_controller #(
    .RESET_PC    (64'h0),
    .PC_STEP     (4),
    .START_DELAY (D0_DELAY),
    .HALT_WORD   (HLT),
    .NOP_WORD    (NOP)
  ) dut0 (
    .CLK   (CLK),
    .RESET (rst),
    .bus   (bus0)
  );

  fetch_controller #(
    .RESET_PC    (64'hFFFF_FFFF_FFFF_FFFC),
    .PC_STEP     (4),
    .START_DELAY (0),
    .HALT_WORD   (HLT),
    .NOP_WORD    (NOP)
  ) dut1 (
    .CLK   (CLK),
    .RESET (rst),
    .bus   (bus1)
  );

  function automatic logic [31:0] im_word(input logic [63:0] a);
    if (a == halt_addr) return HLT;
    return a[31:0] + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: one clock edge with the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      m_pc = 64'h0; m_if_pc = 64'h0; m_if_instr = NOP; m_if_valid = 1'b0;
      m_halted = 1'b0; m_count = 32'd0; m_idle = D0_DELAY;
    end else if (m_idle > 0) begin
      if (br) m_pc = {tgt[63:2], 2'b00};
      m_idle--;
    end else if (m_halted) begin
      m_if_instr = NOP; m_if_valid = 1'b0;
      if (br) begin
        m_pc = {tgt[63:2], 2'b00};
        m_halted = 1'b0;
      end
    end else if (br) begin
      m_pc = {tgt[63:2], 2'b00};
      m_if_instr = NOP; m_if_valid = 1'b0;
    end else if (!stall) begin
      m_if_pc = m_pc; m_if_instr = instr; m_if_valid = 1'b1;
      m_count = m_count + 32'd1;
      if (instr == HLT) m_halted = 1'b1;
      else              m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic check_all();
    chk("Address",           bus0.Address,                m_pc);
    chk("IF_ID_PC",          bus0.IF_ID_PC,               m_if_pc);
    chk("IF_ID_Instruction", 64'(bus0.IF_ID_Instruction), 64'(m_if_instr));
    chk("IF_ID_Valid",       64'(bus0.IF_ID_Valid),       64'(m_if_valid));
    chk("Halted",            64'(bus0.Halted),            64'(m_halted));
    chk("FetchCount",        64'(bus0.FetchCount),        64'(m_count));
  endtask

  task automatic tick();
    instr = im_word(bus0.Address);
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 64'h0; instr = 32'h0;
    halt_addr = '1;

    // Reset; zero-delay instance starts at the top of the address space
    tick();
    chk("rst_addr",     bus0.Address, 64'h0);
    chk("d1_rst_addr",  bus1.Address, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("d1_rst_valid", 64'(bus1.IF_ID_Valid), 64'd0);
    rst = 1'b0;

    // First edge: zero-delay instance fetches at ...FFFC and wraps to 0
    tick();
    chk("d1_if_pc",  bus1.IF_ID_PC, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("d1_instr",  64'(bus1.IF_ID_Instruction), 64'h0000_00FC);
    chk("d1_valid",  64'(bus1.IF_ID_Valid), 64'd1);
    chk("d1_wrap",   bus1.Address, 64'h0);
    chk("t1_wait",   bus0.Address, 64'h0);
    tick();
    tick();
    chk("t1_first",  64'(bus0.IF_ID_Instruction), 64'h100);
    tick();
    chk("t1_second", bus0.IF_ID_PC, 64'h4);
    chk("t1_count",  64'(bus0.FetchCount), 64'd2);

    // Stall three cycles at PC=8
    stall = 1'b1;
    repeat (3) tick();
    chk("t2_addr",  bus0.Address, 64'h8);
    chk("t2_ifpc",  bus0.IF_ID_PC, 64'h4);
    stall = 1'b0;
    tick();
    chk("t2_resume", bus0.IF_ID_PC, 64'h8);
    tick();

    // Branch with simultaneous stall at PC=0x10
    chk("t3_pc", bus0.Address, 64'h10);
    br = 1'b1; stall = 1'b1; tgt = 64'h41;
    tick();
    br = 1'b0; stall = 1'b0;
    chk("t3_addr",  bus0.Address, 64'h40);
    chk("t3_instr", 64'(bus0.IF_ID_Instruction), 64'(NOP));
    chk("t3_count", 64'(bus0.FetchCount), 64'd4);

    // Halt at 0x20, hold ten cycles, branch out to 0x80
    halt_addr = 64'h20; br = 1'b1; tgt = 64'h20;
    tick();
    br = 1'b0;
    tick();
    chk("t4_hlt",    64'(bus0.IF_ID_Instruction), 64'(HLT));
    chk("t4_halted", 64'(bus0.Halted), 64'd1);
    repeat (10) begin
      tick();
      chk("t4_hold", bus0.Address, 64'h20);
    end
    br = 1'b1; tgt = 64'h80;
    tick();
    br = 1'b0;
    chk("t4_exit", 64'(bus0.Halted), 64'd0);
    tick();
    chk("t4_resume", bus0.IF_ID_PC, 64'h80);

    // Reset during a branch, then during HALT
    br = 1'b1; tgt = 64'h1000; rst = 1'b1;
    tick();
    br = 1'b0; rst = 1'b0;
    chk("t6_addr",  bus0.Address, 64'h0);
    chk("t6_count", 64'(bus0.FetchCount), 64'd0);
    tick();
    tick();
    chk("t6_wait", bus0.Address, 64'h0);
    halt_addr = 64'h4;
    repeat (3) tick();
    chk("t6_halted", 64'(bus0.Halted), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_clear", 64'(bus0.Halted), 64'd0);
    chk("t6_bubble", 64'(bus0.IF_ID_Valid), 64'd0);

    // Randomized traffic against the model
    halt_addr = '1;
    repeat (400) begin
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 9) == 0);
      tgt   = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0)
        halt_addr = m_pc + 64'(4 * $urandom_range(0, 6));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
